// File: rtl/bist_pkg.sv
// Shared types and default widths for the BIST sequencer and its datapath.
package bist_pkg;

  localparam int SIG_W_DEF = 4;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_RUN,
    ST_SETTLE,
    ST_CMP
  } bist_state_e;

endpackage

// File: rtl/bist_pat_cnt.sv
// Pattern down-counter (remaining patterns) plus the applied-pattern counter.
module bist_pat_cnt
  import bist_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             load_i,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             run_i,
  output logic             rem_zero_o,
  output logic             rem_last_o,
  output logic [CNT_W-1:0] applied_o
);

  logic [CNT_W-1:0] rem_q;
  logic [CNT_W-1:0] applied_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      rem_q     <= '0;
      applied_q <= '0;
    end else if (load_i) begin
      rem_q     <= cnt_i;
      applied_q <= '0;
    end else if (run_i) begin
      rem_q     <= rem_q - CNT_W'(1);
      applied_q <= applied_q + CNT_W'(1);
    end
  end

  assign rem_zero_o = (rem_q == '0);
  assign rem_last_o = (rem_q == CNT_W'(1));
  assign applied_o  = applied_q;

endmodule

// File: rtl/bist_seq_ctrl.sv
// BIST sequencer: seeds LFSR/SISR, runs pat_cnt patterns, compares signature.
module bist_seq_ctrl
  import bist_pkg::*;
#(
  parameter int SIG_W = SIG_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] pat_cnt,
  input  logic [SIG_W-1:0] golden,
  input  logic [SIG_W-1:0] sig,
  output logic             lfsr_rst_b,
  output logic             lfsr_en,
  output logic             sisr_rst_b,
  output logic             sisr_en,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [CNT_W-1:0] applied
);

  bist_state_e      state_q, state_d;
  logic [SIG_W-1:0] golden_q;
  logic             accept;
  logic             run_adv;
  logic             rem_zero, rem_last;
  logic             seed_rst_b_q, en_q, busy_q, done_q, pass_q, fail_q;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          accept  = 1'b1;
          state_d = ST_INIT;
        end
      end
      ST_INIT:   state_d = abort ? ST_IDLE : (rem_zero ? ST_SETTLE : ST_RUN);
      ST_RUN:    state_d = abort ? ST_IDLE : (rem_last ? ST_SETTLE : ST_RUN);
      ST_SETTLE: state_d = abort ? ST_IDLE : ST_CMP;
      ST_CMP:    state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // An aborted RUN cycle still had its enables high, so it still counts.
  assign run_adv = (state_q == ST_RUN);

  bist_pat_cnt #(.CNT_W(CNT_W)) u_pat_cnt (
    .clk        (clk),
    .rst_b      (rst_b),
    .load_i     (accept),
    .cnt_i      (pat_cnt),
    .run_i      (run_adv),
    .rem_zero_o (rem_zero),
    .rem_last_o (rem_last),
    .applied_o  (applied)
  );

  // Outputs are decoded from the next state so they line up with the state.
  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state_q      <= ST_IDLE;
      golden_q     <= '0;
      seed_rst_b_q <= 1'b0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      seed_rst_b_q <= (state_d != ST_INIT);
      en_q         <= (state_d == ST_RUN);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_q == ST_CMP);
      if (accept) begin
        golden_q <= golden;
        pass_q   <= 1'b0;
        fail_q   <= 1'b0;
      end else if (state_q == ST_CMP) begin
        pass_q <= (sig == golden_q);
        fail_q <= (sig != golden_q);
      end
    end
  end

  assign lfsr_rst_b = seed_rst_b_q;
  assign sisr_rst_b = seed_rst_b_q;
  assign lfsr_en    = en_q;
  assign sisr_en    = en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail       = fail_q;

endmodule

// File: tb/tb_bist_seq_ctrl.sv
// Self-checking bench: cycle-offset model of a BIST run plus directed scenarios.
module tb_bist_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_b = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [4:0] pat_cnt = '0;
  logic [3:0] golden = '0;
  logic [3:0] sig_drv = '0;
  logic       use_sisr = 1'b0;
  logic [3:0] sig;
  logic       lfsr_rst_b, lfsr_en, sisr_rst_b, sisr_en;
  logic       busy, done, pass, fail;
  logic [4:0] applied;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int t;
  int en_cnt, first_en, last_en, done_off;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bist_seq_ctrl dut (
    .clk(clk), .rst_b(rst_b), .start(start), .abort(abort),
    .pat_cnt(pat_cnt), .golden(golden), .sig(sig),
    .lfsr_rst_b(lfsr_rst_b), .lfsr_en(lfsr_en),
    .sisr_rst_b(sisr_rst_b), .sisr_en(sisr_en),
    .busy(busy), .done(done), .pass(pass), .fail(fail), .applied(applied)
  );

  // External test environment: LFSR, circuit under test and SISR.
  localparam logic [3:0] SEED = 4'h1;
  logic [3:0] lfsr_q, sisr_q;

  function automatic logic [3:0] lfsr_next(input logic [3:0] l);
    return {l[2:0], l[3] ^ l[2]};
  endfunction
  function automatic logic [3:0] cut(input logic [3:0] l);
    return l ^ {l[0], l[3:1]};
  endfunction
  function automatic logic [3:0] sisr_next(input logic [3:0] s, input logic [3:0] d);
    return {s[2:0], s[3] ^ s[2]} ^ d;
  endfunction
  function automatic logic [3:0] ref_sig(input int n);
    logic [3:0] l, s;
    l = SEED;
    s = '0;
    for (int i = 0; i < n; i++) begin
      s = sisr_next(s, cut(l));
      l = lfsr_next(l);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    if (!lfsr_rst_b)  lfsr_q <= SEED;
    else if (lfsr_en) lfsr_q <= lfsr_next(lfsr_q);
    if (!sisr_rst_b)  sisr_q <= '0;
    else if (sisr_en) sisr_q <= sisr_next(sisr_q, cut(lfsr_q));
  end

  assign sig = use_sisr ? sisr_q : sig_drv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: everything is a function of the cycle offset d from the accepted start.
  logic        mv = 1'b0, in_rst = 1'b0, have_run = 1'b0, aborted = 1'b0, exp_pass = 1'b0;
  int          ts, n, ta, d, end_d, e_app;
  logic [3:0]  gold_l;
  logic [12:0] e, act;

  always @(negedge clk) begin
    e   = '0;
    act = {busy, done, pass, fail, lfsr_rst_b, sisr_rst_b, lfsr_en, sisr_en, applied};
    if (mv) begin
      if (in_rst) e = '0;
      else if (!have_run) e = {4'b0000, 2'b11, 2'b00, 5'd0};
      else begin
        d     = cyc - ts;
        end_d = aborted ? (ta - ts + 1) : (n + 4);
        e_app = ((d < end_d) ? d : end_d) - 2;
        if (e_app < 0) e_app = 0;
        if (e_app > n) e_app = n;
        e[12]   = (d < end_d);
        e[11]   = !aborted && (d == n + 4);
        e[10]   = !aborted && (d >= n + 4) && exp_pass;
        e[9]    = !aborted && (d >= n + 4) && !exp_pass;
        e[8]    = (d != 1);
        e[7]    = (d != 1);
        e[6]    = (d >= 2) && (d <= n + 1) && (d < end_d);
        e[5]    = e[6];
        e[4:0]  = e_app[4:0];
      end
      check("cycle_outputs", {19'd0, act}, {19'd0, e});
    end
    if (!rst_b) begin
      mv       = 1'b1;
      in_rst   = 1'b1;
      have_run = 1'b0;
    end else if (mv) begin
      in_rst = 1'b0;
      if (!e[12] && start && !abort) begin
        have_run = 1'b1;
        aborted  = 1'b0;
        ts       = cyc;
        n        = int'(pat_cnt);
        gold_l   = golden;
      end else if (have_run && !aborted && e[12]) begin
        if (cyc - ts == n + 3) exp_pass = (sig == gold_l);
        else if (abort) begin
          aborted = 1'b1;
          ta      = cyc;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic launch(input int cnt, input logic [3:0] g);
    tick();
    start   = 1'b1;
    pat_cnt = cnt[4:0];
    golden  = g;
    t       = cyc;
    tick();
    start   = 1'b0;
  endtask

  task automatic wait_done(input int t0, input int max_cyc,
                           output int ec, output int fe, output int le, output int doff);
    ec = 0; fe = -1; le = -1; doff = -1;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (lfsr_en) begin
        ec++;
        if (fe < 0) fe = cyc - t0;
        le = cyc - t0;
      end
      if (done) begin
        doff = cyc - t0;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] g;

    // Reset for two edges, then release.
    tick();
    sample();
    check("reset_outputs",
          {19'd0, busy, done, pass, fail, lfsr_rst_b, sisr_rst_b, lfsr_en, sisr_en, applied}, 32'd0);
    tick();
    rst_b = 1'b1;
    tick();
    sample();
    check("release_resets", {30'd0, lfsr_rst_b, sisr_rst_b}, 32'd3);
    check("release_idle", {31'd0, busy}, 32'd0);

    // Five patterns, signature matches.
    sig_drv = 4'h6;
    launch(5, 4'h6);
    wait_done(t, 40, en_cnt, first_en, last_en, done_off);
    check("p5_en_cycles", en_cnt, 5);
    check("p5_first_en", first_en, 2);
    check("p5_last_en", last_en, 6);
    check("p5_done_off", done_off, 9);
    check("p5_pass_fail", {30'd0, pass, fail}, 32'd2);
    check("p5_applied", {27'd0, applied}, 32'd5);

    // Five patterns, signature mismatch; a new start then clears fail.
    sig_drv = 4'h7;
    launch(5, 4'h6);
    wait_done(t, 40, en_cnt, first_en, last_en, done_off);
    check("p5m_done_off", done_off, 9);
    check("p5m_pass_fail", {30'd0, pass, fail}, 32'd1);
    launch(2, 4'h7);
    sample();
    check("restart_clears", {30'd0, pass, fail}, 32'd0);
    wait_done(t, 40, en_cnt, first_en, last_en, done_off);
    check("p2_done_off", done_off, 6);

    // Zero patterns.
    sig_drv = 4'h3;
    launch(0, 4'h3);
    wait_done(t, 40, en_cnt, first_en, last_en, done_off);
    check("p0_en_cycles", en_cnt, 0);
    check("p0_done_off", done_off, 4);
    check("p0_pass", {31'd0, pass}, 32'd1);

    // Maximum count.
    launch(31, 4'h3);
    wait_done(t, 80, en_cnt, first_en, last_en, done_off);
    check("p31_en_cycles", en_cnt, 31);
    check("p31_applied", {27'd0, applied}, 32'd31);
    check("p31_done_off", done_off, 35);

    // Abort in the third RUN cycle; a mid-run start is ignored.
    launch(10, 4'h3);
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sample();
    check("abort_idle", {30'd0, busy, lfsr_en}, 32'd0);
    check("abort_applied", {27'd0, applied}, 32'd3);
    check("abort_pass_fail", {30'd0, pass, fail}, 32'd0);
    wait_done(t, 20, en_cnt, first_en, last_en, done_off);
    check("abort_no_done", done_off, -1);

    // Start together with abort in IDLE is refused.
    tick();
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    sample();
    check("start_abort_idle", {31'd0, busy}, 32'd0);

    // Abort during CMP is ignored.
    launch(1, 4'h3);
    tick();
    tick();
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    sample();
    check("cmp_abort_done", {30'd0, done, pass}, 32'd3);

    // Reset mid-run abandons the run.
    launch(10, 4'h3);
    tick();
    tick();
    rst_b = 1'b0;
    tick();
    rst_b = 1'b1;
    sample();
    check("midrun_reset",
          {19'd0, busy, done, pass, fail, lfsr_rst_b, sisr_rst_b, lfsr_en, sisr_en, applied}, 32'd0);
    wait_done(t, 20, en_cnt, first_en, last_en, done_off);
    check("midrun_reset_no_done", done_off, -1);

    // Full system with the environment LFSR/CUT/SISR.
    use_sisr = 1'b1;
    g = ref_sig(31);
    launch(31, g);
    wait_done(t, 80, en_cnt, first_en, last_en, done_off);
    check("sys_pass", {30'd0, pass, fail}, 32'd2);
    launch(31, g ^ 4'h1);
    wait_done(t, 80, en_cnt, first_en, last_en, done_off);
    check("sys_fail", {30'd0, pass, fail}, 32'd1);

    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
